// File: rtl/tmnt_audio_pkg.sv
// Shared types, constants and the output saturation helper for the TMNT audio mixer.
package tmnt_audio_pkg;

    localparam int ACC_W   = 25;
    localparam int PCM_MID = 64;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE,
        MUL_YM,
        MUL_A,
        MUL_B,
        SUM,
        LPF,
        OUT
    } state_t;

    function automatic logic signed [15:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > ACC_W'(SAT_MAX))
            return 16'sh7FFF;
        else if (a < ACC_W'(SAT_MIN))
            return 16'sh8000;
        else
            return a[15:0];
    endfunction

endpackage

// File: rtl/tmnt_mix_mac.sv
// Single signed multiplier plus accumulator, shared by the YM and both PCM terms.
module tmnt_mix_mac
    import tmnt_audio_pkg::*;
#(
    parameter int PCM_SHIFT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic signed [15:0]      i_a,
    input  logic signed [8:0]       i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod = $signed({{9{i_a[15]}}, i_a}) * $signed({{16{i_b[8]}}, i_b});

    // A clearing cycle carries the Q2.6 YM term; accumulate cycles carry PCM terms.
    assign w_term = i_clr ? (w_prod >>> 6) : (w_prod <<< PCM_SHIFT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= i_clr ? w_term : r_acc + w_term;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/tmnt_audio_mixer.sv
// YM2151 + 2x K007232 mono mixer, one shared multiplier sequenced by an FSM.
// Optional board RC low-pass model enabled by defining TMNT_MIX_LPF_EN.
module tmnt_audio_mixer
    import tmnt_audio_pkg::*;
#(
    parameter int YM_GAIN   = 64,
    parameter int PCM_SHIFT = 4
`ifdef TMNT_MIX_LPF_EN
    ,
    parameter int LPF_SHIFT = 2
`endif
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        SAMPLE_TICK,
    input  logic [15:0] YM_IN,
    input  logic [6:0]  PCM_A,
    input  logic [6:0]  PCM_B,
    input  logic [3:0]  LEVEL_A,
    input  logic [3:0]  LEVEL_B,
    output logic [15:0] AUDIO_OUT,
    output logic        OUT_VALID,
    output logic        OVERRUN
);

    localparam logic [7:0] YM_GAIN8 = YM_GAIN[7:0];

    state_t r_state, w_next;

    logic [15:0] r_ym;
    logic [6:0]  r_pcm_a, r_pcm_b;
    logic [3:0]  r_lvl_a, r_lvl_b;
    logic [15:0] r_audio;
    logic        r_valid;
    logic        r_overrun;

    logic                    w_mac_en, w_mac_clr;
    logic signed [15:0]      w_a;
    logic signed [8:0]       w_b;
    logic signed [ACC_W-1:0] w_acc;
    logic [7:0]              w_off_a, w_off_b;

    assign w_off_a = {1'b0, r_pcm_a} - 8'(PCM_MID);
    assign w_off_b = {1'b0, r_pcm_b} - 8'(PCM_MID);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_mac_en  = 1'b0;
        w_mac_clr = 1'b0;
        w_a       = '0;
        w_b       = '0;
        case (r_state)
            IDLE:   if (SAMPLE_TICK) w_next = MUL_YM;
            MUL_YM: begin
                w_mac_en  = 1'b1;
                w_mac_clr = 1'b1;
                w_a       = r_ym;
                w_b       = {1'b0, YM_GAIN8};
                w_next    = MUL_A;
            end
            MUL_A: begin
                w_mac_en = 1'b1;
                w_a      = {{8{w_off_a[7]}}, w_off_a};
                w_b      = {5'b0, r_lvl_a};
                w_next   = MUL_B;
            end
            MUL_B: begin
                w_mac_en = 1'b1;
                w_a      = {{8{w_off_b[7]}}, w_off_b};
                w_b      = {5'b0, r_lvl_b};
                w_next   = SUM;
            end
`ifdef TMNT_MIX_LPF_EN
            SUM:    w_next = LPF;
`else
            SUM:    w_next = OUT;
`endif
            LPF:    w_next = OUT;
            OUT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    tmnt_mix_mac #(
        .PCM_SHIFT (PCM_SHIFT)
    ) u_mac (
        .i_clk   (CLK),
        .i_rst_n (nRESET),
        .i_en    (w_mac_en),
        .i_clr   (w_mac_clr),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_acc   (w_acc)
    );

`ifdef TMNT_MIX_LPF_EN
    logic [15:0]        r_sat;
    logic signed [16:0] w_diff, w_step;
    logic [15:0]        w_lpf;

    // Result always lies between y and x, so the 16-bit add cannot wrap.
    assign w_diff = {r_sat[15], r_sat} - {r_audio[15], r_audio};
    assign w_step = w_diff >>> LPF_SHIFT;
    assign w_lpf  = r_audio + w_step[15:0];
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ym      <= '0;
            r_pcm_a   <= '0;
            r_pcm_b   <= '0;
            r_lvl_a   <= '0;
            r_lvl_b   <= '0;
            r_audio   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef TMNT_MIX_LPF_EN
            r_sat     <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (SAMPLE_TICK) begin
                if (r_state == IDLE) begin
                    r_ym    <= YM_IN;
                    r_pcm_a <= PCM_A;
                    r_pcm_b <= PCM_B;
                    r_lvl_a <= LEVEL_A;
                    r_lvl_b <= LEVEL_B;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            case (r_state)
`ifdef TMNT_MIX_LPF_EN
                SUM: r_sat <= saturate(w_acc);
                LPF: begin
                    r_audio <= w_lpf;
                    r_valid <= 1'b1;
                end
`else
                // Registering into OUT makes the pulse and the new sample coincide.
                SUM: begin
                    r_audio <= saturate(w_acc);
                    r_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign AUDIO_OUT = r_audio;
    assign OUT_VALID = r_valid;
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_tmnt_audio_mixer.sv
// Directed self-checking bench for tmnt_audio_mixer (default build and TMNT_MIX_LPF_EN build).
module tb_tmnt_audio_mixer;

`ifdef TMNT_MIX_LPF_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        SAMPLE_TICK;
    logic [15:0] YM_IN;
    logic [6:0]  PCM_A, PCM_B;
    logic [3:0]  LEVEL_A, LEVEL_B;
    logic [15:0] AUDIO_OUT;
    logic        OUT_VALID;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    tmnt_audio_mixer dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .SAMPLE_TICK (SAMPLE_TICK),
        .YM_IN       (YM_IN),
        .PCM_A       (PCM_A),
        .PCM_B       (PCM_B),
        .LEVEL_A     (LEVEL_A),
        .LEVEL_B     (LEVEL_B),
        .AUDIO_OUT   (AUDIO_OUT),
        .OUT_VALID   (OUT_VALID),
        .OVERRUN     (OVERRUN)
    );

    // Tick at negedge of cycle 0, scramble inputs afterwards, expect a single pulse at cycle LAT.
    task automatic run_sample(input logic [15:0] ym, input logic [6:0] pa, input logic [6:0] pb,
                              input logic [3:0] la, input logic [3:0] lb,
                              input logic [15:0] exp, input string name);
        int first = -1;
        int width = 0;
        logic [15:0] got = 16'hxxxx;
        @(negedge CLK);
        YM_IN = ym; PCM_A = pa; PCM_B = pb; LEVEL_A = la; LEVEL_B = lb;
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        YM_IN = ~ym; PCM_A = ~pa; PCM_B = ~pb; LEVEL_A = ~la; LEVEL_B = ~lb;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (k > 1) @(negedge CLK);
            if (OUT_VALID === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    got = AUDIO_OUT;
                end
                width++;
            end
        end
        checks++;
        if (first !== LAT || width !== 1) begin
            errors++;
            $display("FAIL %s timing: pulse at cycle %0d width %0d, required cycle %0d width 1",
                     name, first, width, LAT);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s value: got %0d, required %0d", name, $signed(got), $signed(exp));
        end
        checks++;
        if (AUDIO_OUT !== exp) begin
            errors++;
            $display("FAIL %s hold: got %0d, required %0d", name, $signed(AUDIO_OUT), $signed(exp));
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0; SAMPLE_TICK = 1'b0;
        YM_IN = 16'h1234; PCM_A = 7'd5; PCM_B = 7'd99; LEVEL_A = 4'd7; LEVEL_B = 4'd3;
        repeat (3) @(negedge CLK);
        checks += 3;
        if (AUDIO_OUT !== 16'd0) begin errors++; $display("FAIL reset AUDIO_OUT: got %h, required 0000", AUDIO_OUT); end
        if (OUT_VALID !== 1'b0)  begin errors++; $display("FAIL reset OUT_VALID: got %b, required 0", OUT_VALID); end
        if (OVERRUN !== 1'b0)    begin errors++; $display("FAIL reset OVERRUN: got %b, required 0", OVERRUN); end
        nRESET = 1'b1;
        run_sample(16'd0, 7'd64, 7'd64, 4'd15, 4'd15, 16'd0, "midpoint");
    endtask

    task automatic test_ym_only();
        run_sample(16'd1000, 7'd64, 7'd64, 4'd15, 4'd15, 16'd1000, "ym_pos");
        run_sample(16'hFC18, 7'd64, 7'd64, 4'd15, 4'd15, 16'hFC18, "ym_neg");
        run_sample(16'hFFFF, 7'd64, 7'd64, 4'd0, 4'd0, 16'hFFFF, "ym_minus1");
    endtask

    task automatic test_pcm();
        run_sample(16'd0, 7'd127, 7'd0, 4'd15, 4'd15, 16'hFF10, "pcm_scale");
        // 7 + (0-64)*1*16 = -1017
        run_sample(16'd7, 7'd0, 7'd64, 4'd1, 4'd9, 16'hFC07, "pcm_a_lvl1");
        // 100 + 63*1*16 = 1108
        run_sample(16'd100, 7'd64, 7'd127, 4'd15, 4'd1, 16'd1108, "pcm_b_lvl1");
    endtask

    task automatic test_saturation();
        run_sample(16'h7FFF, 7'd127, 7'd127, 4'd15, 4'd15, 16'h7FFF, "sat_hi");
        run_sample(16'h8000, 7'd0, 7'd0, 4'd15, 4'd15, 16'h8000, "sat_lo");
    endtask

    task automatic test_zero_terms();
        run_sample(16'd0, 7'd127, 7'd0, 4'd0, 4'd0, 16'd0, "level_zero");
        run_sample(16'd300, 7'd64, 7'd64, 4'd15, 4'd15, 16'd300, "pcm_mid");
    endtask

    task automatic test_overrun();
        int first = -1;
        int width = 0;
        logic [15:0] got = 16'hxxxx;
        @(negedge CLK);
        YM_IN = 16'd1000; PCM_A = 7'd64; PCM_B = 7'd64; LEVEL_A = 4'd15; LEVEL_B = 4'd15;
        SAMPLE_TICK = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge CLK);
            SAMPLE_TICK = (k == 2);
            if (k == 2) YM_IN = 16'hFC18;
            if (k == 2) begin
                checks++;
                if (OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun early: got %b, required 0", OVERRUN); end
            end
            if (k == 3) begin
                checks++;
                if (OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun set: got %b, required 1", OVERRUN); end
            end
            if (OUT_VALID === 1'b1) begin
                if (first < 0) begin first = k; got = AUDIO_OUT; end
                width++;
            end
        end
        SAMPLE_TICK = 1'b0;
        checks += 3;
        if (first !== LAT || width !== 1) begin
            errors++;
            $display("FAIL overrun timing: pulse at cycle %0d width %0d, required cycle %0d width 1", first, width, LAT);
        end
        if (got !== 16'd1000) begin errors++; $display("FAIL overrun value: got %0d, required 1000", $signed(got)); end
        if (OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b, required 1", OVERRUN); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge CLK);
        YM_IN = 16'd5000; PCM_A = 7'd64; PCM_B = 7'd64; LEVEL_A = 4'd0; LEVEL_B = 4'd0;
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        repeat (2) @(negedge CLK);
        nRESET = 1'b0;
        #1;
        checks += 3;
        if (AUDIO_OUT !== 16'd0) begin errors++; $display("FAIL reset_mid AUDIO_OUT: got %h, required 0000", AUDIO_OUT); end
        if (OUT_VALID !== 1'b0)  begin errors++; $display("FAIL reset_mid OUT_VALID: got %b, required 0", OUT_VALID); end
        if (OVERRUN !== 1'b0)    begin errors++; $display("FAIL reset_mid OVERRUN: got %b, required 0", OVERRUN); end
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses !== 0) begin errors++; $display("FAIL reset_mid stray pulse: got %0d pulses, required 0", pulses); end
        if (AUDIO_OUT !== 16'd0) begin errors++; $display("FAIL reset_mid hold: got %h, required 0000", AUDIO_OUT); end
    endtask

    task automatic test_tick_at_out();
        int pulses = 0;
        logic [15:0] exp;
`ifdef TMNT_MIX_LPF_EN
        exp = 16'd500;
`else
        exp = 16'd2000;
`endif
        @(negedge CLK);
        YM_IN = 16'd2000; PCM_A = 7'd64; PCM_B = 7'd64; LEVEL_A = 4'd15; LEVEL_B = 4'd15;
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        repeat (LAT - 1) @(negedge CLK);
        checks += 2;
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL out_tick pulse: got %b, required 1", OUT_VALID); end
        if (AUDIO_OUT !== exp)  begin errors++; $display("FAIL out_tick value: got %0d, required %0d", $signed(AUDIO_OUT), $signed(exp)); end
        YM_IN = 16'd3000;
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        checks++;
        if (OVERRUN !== 1'b1) begin errors++; $display("FAIL out_tick overrun: got %b, required 1", OVERRUN); end
        for (int k = 0; k < LAT + 4; k++) begin
            if (OUT_VALID === 1'b1) pulses++;
            @(negedge CLK);
        end
        checks += 2;
        if (pulses !== 0)      begin errors++; $display("FAIL out_tick ignored: got %0d pulses, required 0", pulses); end
        if (AUDIO_OUT !== exp) begin errors++; $display("FAIL out_tick hold: got %0d, required %0d", $signed(AUDIO_OUT), $signed(exp)); end
    endtask

`ifdef TMNT_MIX_LPF_EN
    task automatic test_lpf_step();
        run_sample(16'd4096, 7'd64, 7'd64, 4'd15, 4'd15, 16'd1024, "lpf_step1");
        run_sample(16'd4096, 7'd64, 7'd64, 4'd15, 4'd15, 16'd1792, "lpf_step2");
        run_sample(16'd4096, 7'd64, 7'd64, 4'd15, 4'd15, 16'd2368, "lpf_step3");
        run_sample(16'd4096, 7'd64, 7'd64, 4'd15, 4'd15, 16'd2800, "lpf_step4");
    endtask
`endif

    initial begin
        test_reset();
`ifdef TMNT_MIX_LPF_EN
        test_lpf_step();
`else
        test_ym_only();
        test_pcm();
        test_saturation();
        test_zero_terms();
        test_overrun();
`endif
        test_reset_mid();
        test_tick_at_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
